// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state type and RV32I width/opcode encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Also flags misaligned addresses and func3 codes outside the load set.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store lanes: replicate the datum and shift the enables to the lane.
  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    unique case (func3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << addr_lo;
      end
      default: ;
    endcase
  end

  // Load extraction: pick the byte/half lane, then sign or zero extend.
  always_comb begin
    shifted  = mem_rdata >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = '0;
    illegal  = 1'b0;
    unique case (func3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_ext = mem_rdata;
      F3_BU:   load_ext = {24'd0, byte_sel};
      F3_HU:   load_ext = {16'd0, half_sel};
      default: illegal  = 1'b1;
    endcase
  end

  // Halfwords need bit 0 clear, words need both low bits clear.
  always_comb begin
    misaligned = ((func3[1:0] == 2'b01) & addr_lo[0])
               | ((func3[1:0] == 2'b10) & (|addr_lo));
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I memory access per request.
// Stalls the pipeline until the bus completes, errors or times out.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        req;
  logic        bad;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_load;
  logic        al_mis;
  logic        al_ill;

  // In IDLE the aligner sees the live request, afterwards the latched one.
  always_comb begin
    req   = req_valid & (is_load | is_store);
    al_f3 = (state_q == IDLE) ? func3 : f3_q;
    al_lo = (state_q == IDLE) ? addr[1:0] : addr_q[1:0];
    bad   = al_ill | al_mis | (is_load & is_store)
          | (is_store & func3[2]);
  end

  lsu_align u_align (
    .func3      (al_f3),
    .addr_lo    (al_lo),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .wdata      (al_wdata),
    .be         (al_be),
    .load_ext   (al_load),
    .misaligned (al_mis),
    .illegal    (al_ill)
  );

  // Next-state logic: validate, access with timeout, report completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    err_d   = err_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (bad) begin
            err_d   = 1'b1;
            ld_d    = '0;
            state_d = DONE;
          end else begin
            addr_d  = addr;
            f3_d    = func3;
            we_d    = is_store;
            wdata_d = al_wdata;
            be_d    = al_be;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (!we_q) ld_d = al_load;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ld_d    = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Outputs: stall is combinational in IDLE so the PC holds at once.
  always_comb begin
    stall     = (state_q == IDLE) ? req : (state_q == ACCESS);
    done      = (state_q == DONE);
    mem_req   = (state_q == ACCESS);
    mem_we    = we_q;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q;
    mem_be    = be_q;
    err       = err_q;
    load_data = ld_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .is_load    (is_load),
    .is_store   (is_store),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    req_valid  = 1'b1;
    is_load    = ld;
    is_store   = st;
    func3      = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
  endtask

  // Load with ready one cycle after mem_req; returns sampled in DONE.
  task automatic load_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    tick();
    idle_in();
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    func3 = 3'b0; addr = '0; store_data = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests++;
    if (done !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0
        || err !== 1'b0 || load_data !== 32'h0) begin
      fails++;
      $display("FAIL reset: done=%b stall=%b req=%b err=%b ld=%h exp 0",
               done, stall, mem_req, err, load_data);
    end
  endtask

  task automatic test_sw();
    drive(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    #1;
    tests++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL sw_req_cycle: stall=%b req=%b exp 1/0", stall, mem_req);
    end
    tick();
    idle_in();
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100
        || mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF
        || stall !== 1'b1) begin
      fails++;
      $display("FAIL sw_access: req=%b we=%b a=%h be=%b wd=%h st=%b",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || stall !== 1'b0
        || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL sw_done: done=%b err=%b stall=%b req=%b exp 1/0/0/0",
               done, err, stall, mem_req);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL sw_idle: done=%b exp 0", done);
    end
  endtask

  task automatic test_lb();
    load_op(3'b000, 32'h203, 32'h80112233);
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || load_data !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL lb: done=%b err=%b ld=%h exp 1/0/ffffff80",
               done, err, load_data);
    end
    tick();
    load_op(3'b100, 32'h203, 32'h80112233);
    tests++;
    if (load_data !== 32'h00000080) begin
      fails++;
      $display("FAIL lbu: ld=%h exp 00000080", load_data);
    end
    tick();
    load_op(3'b001, 32'h40, 32'h12348001);
    tests++;
    if (load_data !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh: ld=%h exp ffff8001", load_data);
    end
    tick();
    load_op(3'b000, 32'h201, 32'h80117F33);
    tests++;
    if (load_data !== 32'h0000007F) begin
      fails++;
      $display("FAIL lb1: ld=%h exp 0000007f", load_data);
    end
    tick();
  endtask

  task automatic test_sh();
    drive(1'b0, 1'b1, 3'b001, 32'h42, 32'h0000ABCD);
    tick();
    idle_in();
    tests++;
    if (mem_addr !== 32'h40 || mem_be !== 4'b1100
        || mem_wdata !== 32'hABCDABCD || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL sh: a=%h be=%b wd=%h we=%b exp 40/1100/abcdabcd/1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tests++;
    if (load_data !== 32'h0000007F || done !== 1'b1) begin
      fails++;
      $display("FAIL sh_keeps_ld: ld=%h done=%b exp 0000007f/1",
               load_data, done);
    end
    tick();
    drive(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5);
    tick();
    idle_in();
    tests++;
    if (mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5
        || mem_addr !== 32'h10) begin
      fails++;
      $display("FAIL sb: be=%b wd=%h a=%h exp 1000/a5a5a5a5/10",
               mem_be, mem_wdata, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    load_op(3'b101, 32'h42, 32'hABCD1234);
    tests++;
    if (load_data !== 32'h0000ABCD) begin
      fails++;
      $display("FAIL lhu: ld=%h exp 0000abcd", load_data);
    end
    tick();
  endtask

  task automatic bad_req(input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input string nm);
    drive(ld, st, f3, a, 32'h0);
    #1;
    tests++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL %s_req: stall=%b req=%b exp 1/0", nm, stall, mem_req);
    end
    tick();
    idle_in();
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || load_data !== 32'h0
        || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL %s: done=%b err=%b ld=%h req=%b exp 1/1/0/0",
               nm, done, err, load_data, mem_req);
    end
    tick();
  endtask

  task automatic test_errors();
    bad_req(1'b1, 1'b0, 3'b010, 32'h101, "lw_mis");
    load_op(3'b010, 32'h104, 32'h55AA55AA);
    tick();
    bad_req(1'b1, 1'b0, 3'b011, 32'h100, "ld_f3");
    load_op(3'b010, 32'h104, 32'h55AA55AA);
    tick();
    bad_req(1'b1, 1'b0, 3'b101, 32'h43, "lhu_mis");
    bad_req(1'b0, 1'b1, 3'b100, 32'h100, "st_f3");
    bad_req(1'b1, 1'b1, 3'b010, 32'h100, "ld_st");
  endtask

  task automatic test_timeout();
    int n;
    load_op(3'b010, 32'h300, 32'h12345678);
    tests++;
    if (load_data !== 32'h12345678 || err !== 1'b0) begin
      fails++;
      $display("FAIL lw: ld=%h err=%b exp 12345678/0", load_data, err);
    end
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    idle_in();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (mem_req) n++;
      tick();
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || load_data !== 32'h0
        || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL timeout: done=%b err=%b ld=%h req=%b exp 1/1/0/0",
               done, err, load_data, mem_req);
    end
    tests++;
    if (n !== 16) begin
      fails++;
      $display("FAIL timeout_len: req cycles=%0d exp 16", n);
    end
    tick();
    tests++;
    if (err !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL err_hold: err=%b done=%b exp 1/0", err, done);
    end
  endtask

  task automatic test_reset_mid();
    load_op(3'b010, 32'h300, 32'hCAFEF00D);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (mem_req !== 1'b1 || load_data !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL mid_pre: req=%b ld=%h exp 1/cafef00d",
               mem_req, load_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (mem_req !== 1'b0 || done !== 1'b0 || load_data !== 32'h0
        || stall !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: req=%b done=%b ld=%h st=%b exp 0/0/0/0",
               mem_req, done, load_data, stall);
    end
    tick();
    tests++;
    if (done !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_after: done=%b req=%b exp 0/0", done, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    load_op(3'b010, 32'h8, 32'h01020304);
    tick();
    load_op(3'b000, 32'h9, 32'h0000FE00);
    tests++;
    if (load_data !== 32'hFFFFFFFE || done !== 1'b1) begin
      fails++;
      $display("FAIL b2b: ld=%h done=%b exp fffffffe/1", load_data, done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb();
    test_sh();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
